trng_postproc: RTL and testbench

- Post-processing stage directly downstream of the ring-oscillator sampler; consumes its raw entropy bit stream.
- Runs a repetition-count health test on every raw sample.
- Debiases raw samples with a von Neumann extractor and packs the surviving bits into bytes.
- Presents each byte on a one-deep valid/ready output register for the top-level output mux or a host reader.

---
 rtl/trng_postproc.sv | 169 ++++++++++++++++
 tb/tb_trng_postproc.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/trng_postproc.sv
// -----------------------------------------------------------------------------
// trng_postproc
// Post-processing for the ring-oscillator entropy source. Each raw sample first
// goes through a repetition-count health test. It is then debiased by a von
// Neumann extractor, and the surviving bits are packed MSB-first into bytes.
// Each byte is presented on a one-deep valid/ready output register.
//
// Ports
//   clk         system clock
//   rst_n       synchronous reset, active-high (asserted = 1)
//   enable      1 = accept raw samples, 0 = flush pair/packer state
//   raw_bit     raw sample from the sampler
//   raw_valid   raw_bit is valid this cycle (no backpressure)
//   byte_out    packed debiased byte
//   byte_valid  byte_out holds an unread byte
//   byte_ready  consumer takes byte_out when byte_valid && byte_ready
//   health_fail sticky repetition-count failure
//   overflow    sticky: a completed byte was dropped, output register full
// -----------------------------------------------------------------------------
module trng_postproc #(
    parameter int unsigned RCT_CUTOFF = 16,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       raw_bit,
    input  logic       raw_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       health_fail,
    output logic       overflow
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BCNT_W = 3;

    // Health-test state
    logic [CNT_W-1:0]  run_q, run_d;
    logic              last_q, last_d;
    logic              hf_q, hf_d;

    // Extractor and packer state
    logic              pair_flag_q, pair_flag_d;
    logic              pair_bit_q, pair_bit_d;
    logic [BYTE_W-2:0] shift_q, shift_d;
    logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;

    // Output register
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;

    // Combinational helpers
    logic              accept;
    logic              trip;
    logic              emit;
    logic              byte_done;
    logic [BYTE_W-1:0] new_byte;
    logic [CNT_W-1:0]  run_next;

    // Next-state logic for the health test, extractor, packer and output register
    always_comb begin
        run_d       = run_q;
        last_d      = last_q;
        hf_d        = hf_q;
        pair_flag_d = pair_flag_q;
        pair_bit_d  = pair_bit_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        byte_d      = byte_q;
        valid_d     = valid_q;
        ovf_d       = ovf_q;
        emit        = 1'b0;
        byte_done   = 1'b0;
        new_byte    = {shift_q, pair_bit_q};

        accept = raw_valid && enable && !hf_q;

        // A run counter of zero marks "no sample seen yet since reset".
        if ((run_q == CNT_W'(0)) || (raw_bit != last_q)) begin
            run_next = CNT_W'(1);
        end else if (run_q != {CNT_W{1'b1}}) begin
            run_next = run_q + CNT_W'(1);
        end else begin
            run_next = run_q;
        end

        trip = accept && (run_next >= CNT_W'(RCT_CUTOFF));

        if (accept) begin
            run_d  = run_next;
            last_d = raw_bit;
            if (trip) begin
                hf_d = 1'b1;
            end
        end

        // Von Neumann pairing; the tripping sample is never debiased.
        if (!enable) begin
            pair_flag_d = 1'b0;
            shift_d     = '0;
            bit_cnt_d   = '0;
        end else if (accept && !trip) begin
            if (!pair_flag_q) begin
                pair_flag_d = 1'b1;
                pair_bit_d  = raw_bit;
            end else begin
                pair_flag_d = 1'b0;
                emit        = (pair_bit_q != raw_bit);
            end
        end

        // Packer: first emitted bit ends up in bit 7.
        if (emit) begin
            shift_d   = {shift_q[BYTE_W-3:0], pair_bit_q};
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
            byte_done = (bit_cnt_q == BCNT_W'(BYTE_W - 1));
        end

        // Output register: a read in the same cycle frees the slot for a new byte.
        if (hf_q) begin
            valid_d = 1'b0;
        end else if (byte_done) begin
            if (!valid_q || byte_ready) begin
                byte_d  = new_byte;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && byte_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst_n) begin
            run_q       <= '0;
            last_q      <= 1'b0;
            hf_q        <= 1'b0;
            pair_flag_q <= 1'b0;
            pair_bit_q  <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            byte_q      <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            run_q       <= run_d;
            last_q      <= last_d;
            hf_q        <= hf_d;
            pair_flag_q <= pair_flag_d;
            pair_bit_q  <= pair_bit_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_q      <= byte_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign byte_out    = byte_q;
    assign byte_valid  = valid_q;
    assign health_fail = hf_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_trng_postproc.sv
// -----------------------------------------------------------------------------
// tb_trng_postproc
// Directed scenarios plus randomized traffic for trng_postproc. Every cycle is
// compared against a sample-level reference model that tracks run length,
// pending pair bit and a queue of extracted bits.
// -----------------------------------------------------------------------------
module tb_trng_postproc;

    localparam int unsigned CUT = 16;
    localparam logic [15:0] ALT = 16'b10_01_10_10_01_01_10_01; // -> 8'hB2
    localparam logic [15:0] ONE = 16'b10_10_10_10_10_10_10_10; // -> 8'hFF

    logic       clk = 1'b0;
    logic       rst_n, enable, raw_bit, raw_valid, byte_ready;
    logic [7:0] byte_out;
    logic       byte_valid, health_fail, overflow;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int   m_run;
    bit   m_last;
    int   m_pend;
    bit   m_bits[$];
    bit   m_valid;
    int   m_byte;
    bit   m_ovf;
    bit   m_hf;

    trng_postproc #(.RCT_CUTOFF(CUT), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .raw_bit    (raw_bit),
        .raw_valid  (raw_valid),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .health_fail(health_fail),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of reference behaviour, from the pre-edge state and inputs.
    task automatic model_step(input bit r, input bit v, input bit b, input bit en, input bit rdy);
        bit acc, rd, trip, done;
        int nrun, val;
        if (r) begin
            m_run = 0; m_last = 0; m_pend = -1; m_bits.delete();
            m_valid = 0; m_byte = 0; m_ovf = 0; m_hf = 0;
            return;
        end
        acc  = v && en && !m_hf;
        rd   = m_valid && rdy;
        trip = 0;
        done = 0;
        val  = 0;
        if (acc) begin
            if (m_run > 0 && b == m_last) nrun = (m_run < 255) ? m_run + 1 : 255;
            else nrun = 1;
            trip   = (nrun >= int'(CUT));
            m_run  = nrun;
            m_last = b;
        end
        if (!en) begin
            m_pend = -1;
            m_bits.delete();
        end else if (acc && !trip) begin
            if (m_pend < 0) begin
                m_pend = int'(b);
            end else begin
                if (m_pend != int'(b)) m_bits.push_back(bit'(m_pend));
                m_pend = -1;
                if (m_bits.size() == 8) begin
                    foreach (m_bits[i]) val = val * 2 + int'(m_bits[i]);
                    m_bits.delete();
                    done = 1;
                end
            end
        end
        if (m_hf) begin
            m_valid = 0;
        end else if (done) begin
            if (!m_valid || rdy) begin
                m_byte  = val;
                m_valid = 1;
            end else begin
                m_ovf = 1;
            end
        end else if (rd) begin
            m_valid = 0;
        end
        if (trip) m_hf = 1;
    endtask

    // Drive one cycle, advance model and DUT, compare all outputs.
    task automatic step(input bit r, input bit v, input bit b, input bit en, input bit rdy);
        rst_n      = r;
        raw_valid  = v;
        raw_bit    = b;
        enable     = en;
        byte_ready = rdy;
        model_step(r, v, b, en, rdy);
        @(posedge clk);
        #1;
        chk("byte_valid",  32'(byte_valid),  32'(m_valid));
        chk("byte_out",    32'(byte_out),    32'(m_byte));
        chk("health_fail", 32'(health_fail), 32'(m_hf));
        chk("overflow",    32'(overflow),    32'(m_ovf));
    endtask

    task automatic do_reset();
        step(1, 0, 0, 1, 0);
    endtask

    task automatic feed16(input logic [15:0] s, input bit rdy_last);
        for (int i = 0; i < 16; i++) begin
            logic [15:0] t;
            t = s;
            step(0, 1, t[15-i], 1, (i == 15) ? rdy_last : 1'b0);
        end
    endtask

    initial begin
        bit stuck;
        rst_n = 1; enable = 1; raw_bit = 0; raw_valid = 0; byte_ready = 0;
        @(posedge clk);
        #1;

        // Reset state
        do_reset();
        chk("rst_valid", 32'(byte_valid), 32'd0);
        chk("rst_byte",  32'(byte_out),   32'd0);
        chk("rst_hf",    32'(health_fail), 32'd0);
        chk("rst_ovf",   32'(overflow),   32'd0);

        // Basic alternating-pair byte
        feed16(ALT, 0);
        chk("alt_byte",  32'(byte_out),   32'hB2);
        chk("alt_valid", 32'(byte_valid), 32'd1);
        chk("alt_hf",    32'(health_fail), 32'd0);
        step(0, 0, 0, 1, 1);
        chk("alt_read",  32'(byte_valid), 32'd0);
        chk("alt_hold",  32'(byte_out),   32'hB2);

        // Same stream with 00 / 11 pairs interleaved
        for (int k = 0; k < 8; k++) begin
            logic [15:0] t;
            t = ALT;
            step(0, 1, t[15-2*k], 1, 0);
            step(0, 1, t[14-2*k], 1, 0);
            step(0, 1, k[0], 1, 0);
            step(0, 1, k[0], 1, 0);
        end
        chk("ilv_byte",  32'(byte_out),   32'hB2);
        chk("ilv_valid", 32'(byte_valid), 32'd1);
        step(0, 0, 0, 1, 1);

        // Repetition-count trip after exactly 16 ones
        do_reset();
        for (int i = 0; i < 15; i++) step(0, 1, 1, 1, 0);
        chk("rct_15", 32'(health_fail), 32'd0);
        step(0, 1, 1, 1, 0);
        chk("rct_16", 32'(health_fail), 32'd1);
        feed16(ALT, 0);
        chk("rct_novalid", 32'(byte_valid), 32'd0);
        do_reset();
        chk("rct_clear", 32'(health_fail), 32'd0);

        // Overflow: second byte dropped while first held
        feed16(ALT, 0);
        feed16(ONE, 0);
        chk("ovf_byte", 32'(byte_out),   32'hB2);
        chk("ovf_flag", 32'(overflow),   32'd1);
        step(0, 0, 0, 1, 1);
        chk("ovf_read", 32'(byte_valid), 32'd0);

        // New byte completes on the same edge as a read
        do_reset();
        feed16(ALT, 0);
        feed16(ONE, 1);
        chk("same_byte",  32'(byte_out),   32'hFF);
        chk("same_valid", 32'(byte_valid), 32'd1);
        chk("same_ovf",   32'(overflow),   32'd0);
        step(0, 0, 0, 1, 1);

        // enable drop flushes partial bits
        do_reset();
        step(0, 1, 1, 1, 0); step(0, 1, 0, 1, 0); step(0, 1, 0, 1, 0);
        step(0, 1, 1, 1, 0); step(0, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("en_novalid", 32'(byte_valid), 32'd0);
        feed16(ALT, 0);
        chk("en_byte",  32'(byte_out),   32'hB2);
        chk("en_valid", 32'(byte_valid), 32'd1);
        chk("en_ovf",   32'(overflow),   32'd0);

        // Randomized traffic with occasional stuck-at-one bursts and resets
        stuck = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) stuck = ~stuck;
            if (i % 500 == 499) begin
                do_reset();
            end else begin
                step(0, $urandom_range(0, 3) != 0,
                     stuck ? 1'b1 : 1'($urandom),
                     $urandom_range(0, 19) != 0,
                     $urandom_range(0, 3) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
